// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Byte/half/word load-store controller between the MEM stage and a
//            word-wide data memory. Sub-word stores use read-modify-write;
//            loads return sign/zero-extended data on a valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_en,
  output logic              o_mem_readEn,
  output logic              o_mem_writeEn,
  output logic [ADDR_W-1:0] o_mem_add,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);
  localparam logic [1:0]        c_size_word = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_word_idx;
  logic [DATA_W-1:0] w_rword;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_merge;

  assign w_accept   = (r_state == S_IDLE) && i_req_valid;
  assign w_word_idx = {2'b00, r_addr[ADDR_W-1:2]};
  // Word 0 is hard-wired to zero regardless of what the memory returns.
  assign w_rword    = (w_word_idx == '0) ? '0 : i_mem_data;

  // Request legality: size, alignment and word-index range.
  always_comb begin
    w_req_err = 1'b0;
    case (i_req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = i_req_addr[0];
      2'b10:   w_req_err = |i_req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
    if ({2'b00, i_req_addr[ADDR_W-1:2]} >= c_mem_words) begin
      w_req_err = 1'b1;
    end
  end

  // Lane extraction, load extension and store merge from the RD-cycle word.
  always_comb begin
    w_byte  = w_rword[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      2'd3:    w_byte = w_rword[31:24];
      default: w_byte = w_rword[7:0];
    endcase
    w_half  = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ext = w_rword;
    endcase
    w_merge = w_rword;
    case (r_size)
      2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merge = r_wdata;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and memory/response output decode; outputs depend only on state.
  always_comb begin
    w_state_nxt   = r_state;
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_rsp_rdata   = '0;
    o_rsp_err     = 1'b0;
    o_mem_en      = 1'b0;
    o_mem_readEn  = 1'b0;
    o_mem_writeEn = 1'b0;
    o_mem_add     = '0;
    o_mem_data    = '0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept) begin
          if (w_req_err) begin
            w_state_nxt = S_RESP;
          end else if (i_req_we && (i_req_size == c_size_word)) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        o_mem_en     = 1'b1;
        o_mem_readEn = 1'b1;
        o_mem_add    = w_word_idx;
        w_state_nxt  = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        o_mem_en      = 1'b1;
        o_mem_writeEn = 1'b1;
        o_mem_add     = w_word_idx;
        o_mem_data    = r_wdata;
        w_state_nxt   = S_RESP;
      end
      default: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = r_rdata;
        o_rsp_err   = r_err;
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Request latch, RD-cycle capture of load data or merged store word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= i_req_we;
        r_size  <= i_req_size;
        r_uns   <= i_req_unsigned;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_rdata <= '0;
        r_err   <= w_req_err;
      end else if (r_state == S_RD) begin
        if (r_we) begin
          r_wdata <= w_merge;
        end else begin
          r_rdata <= w_ext;
        end
      end else if ((r_state == S_RESP) && i_rsp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Self-checking bench for mem_access_ctrl with a behavioural
//            word memory and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_mem_en;
  logic        o_mem_readEn;
  logic        o_mem_writeEn;
  logic [31:0] o_mem_add;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_en(o_mem_en), .o_mem_readEn(o_mem_readEn),
    .o_mem_writeEn(o_mem_writeEn), .o_mem_add(o_mem_add),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h0 : (32'h5A00_0000 ^ (i * 32'h0103_0507));
  endfunction

  // Behavioural data memory: combinational read in RD, write on the edge.
  logic [31:0] mem [0:31];
  logic        mem_init = 1'b0;
  logic [31:0] junk = 32'h0;
  always @(posedge i_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (o_mem_en && o_mem_writeEn && o_mem_add < 32 && o_mem_add != 0) begin
      mem[o_mem_add[4:0]] <= o_mem_data;
    end
  end
  always @(negedge i_clk) junk <= $urandom();
  assign i_mem_data = o_mem_readEn ? ((o_mem_add == 0) ? 32'h0 : mem[o_mem_add[4:0]]) : junk;

  // Reference memory image, updated once per completed transaction.
  logic [31:0] ref_mem [0:31];

  // Cycle invariants that hold in every state.
  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("rd_wr_exclusive", {31'b0, o_mem_readEn & o_mem_writeEn}, 32'h0);
      chk("req_ready_only_idle", {31'b0, o_req_ready}, {31'b0, !(o_mem_en || o_rsp_valid)});
      if (!o_mem_en) begin
        chk("idle_mem_add", o_mem_add, 32'h0);
        chk("idle_mem_data", o_mem_data, 32'h0);
        chk("idle_mem_strobes", {30'b0, o_mem_readEn, o_mem_writeEn}, 32'h0);
      end
      if (!o_rsp_valid) chk("quiet_rsp", o_rsp_rdata | {31'b0, o_rsp_err}, 32'h0);
    end
  end

  // One transaction: model computes phases, read data and merged word.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input logic chk_lit, input logic [31:0] lit_rd, input logic lit_err,
                        input logic chk_wd, input logic [31:0] lit_wd);
    logic        err;
    logic [31:0] widx, old, neww, shifted, exp_rd;
    int          nph;
    int          ph [2];
    int          nbytes;
    widx = addr >> 2;
    err  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || (widx >= 32);
    old    = (!err && widx != 0) ? ref_mem[widx[4:0]] : 32'h0;
    nbytes = 1 << size;
    neww   = old;
    if (!err) for (int b = 0; b < nbytes; b++) neww[8*(addr[1:0]+b) +: 8] = wdata[8*b +: 8];
    shifted = old >> (8 * addr[1:0]);
    exp_rd  = 32'h0;
    if (!err && !we) begin
      if (size == 2'b00) exp_rd = uns ? (shifted & 32'hFF) : {{24{shifted[7]}}, shifted[7:0]};
      else if (size == 2'b01) exp_rd = uns ? (shifted & 32'hFFFF) : {{16{shifted[15]}}, shifted[15:0]};
      else exp_rd = old;
    end
    ph[0] = 0; ph[1] = 0;
    if (err) nph = 0;
    else if (!we) begin nph = 1; ph[0] = 1; end
    else if (size == 2'b10) begin nph = 1; ph[0] = 2; end
    else begin nph = 2; ph[0] = 1; ph[1] = 2; end

    @(negedge i_clk);
    chk("req_ready_before", {31'b0, o_req_ready}, 32'h1);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata;
    @(negedge i_clk);
    i_req_valid = 1'b0; i_req_we = $urandom_range(0, 1); i_req_size = 2'($urandom_range(0, 3));
    i_req_addr = $urandom(); i_req_wdata = $urandom();
    for (int p = 0; p < nph; p++) begin
      if (p > 0) @(negedge i_clk);
      chk("mem_en", {31'b0, o_mem_en}, 32'h1);
      chk("mem_readEn", {31'b0, o_mem_readEn}, {31'b0, ph[p] == 1});
      chk("mem_writeEn", {31'b0, o_mem_writeEn}, {31'b0, ph[p] == 2});
      chk("mem_add", o_mem_add, widx);
      chk("rsp_valid_early", {31'b0, o_rsp_valid}, 32'h0);
      if (ph[p] == 2) begin
        chk("mem_wdata", o_mem_data, neww);
        if (chk_wd) chk("mem_wdata_lit", o_mem_data, lit_wd);
      end
    end
    if (nph > 0) @(negedge i_clk);
    chk("rsp_valid", {31'b0, o_rsp_valid}, 32'h1);
    chk("rsp_rdata", o_rsp_rdata, exp_rd);
    chk("rsp_err", {31'b0, o_rsp_err}, {31'b0, err});
    chk("rsp_mem_en", {31'b0, o_mem_en}, 32'h0);
    if (chk_lit) begin
      chk("rsp_rdata_lit", o_rsp_rdata, lit_rd);
      chk("rsp_err_lit", {31'b0, o_rsp_err}, {31'b0, lit_err});
    end
    i_rsp_ready = (hold == 0);
    i_req_valid = (hold != 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      chk("hold_valid", {31'b0, o_rsp_valid}, 32'h1);
      chk("hold_rdata", o_rsp_rdata, exp_rd);
      chk("hold_err", {31'b0, o_rsp_err}, {31'b0, err});
      chk("hold_req_ready", {31'b0, o_req_ready}, 32'h0);
      if (h == hold - 1) begin i_rsp_ready = 1'b1; i_req_valid = 1'b0; end
    end
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk("after_take_valid", {31'b0, o_rsp_valid}, 32'h0);
    chk("after_take_ready", {31'b0, o_req_ready}, 32'h1);
    if (we && !err && widx != 0) ref_mem[widx[4:0]] = neww;
  endtask

  initial begin
    logic        r_we, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_ad;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'b00;
    i_req_unsigned = 1'b0; i_req_addr = 32'h0; i_req_wdata = 32'h0; i_rsp_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_req_ready", {31'b0, o_req_ready}, 32'h1);
    chk("reset_rsp", {o_rsp_rdata[29:0], o_rsp_valid, o_rsp_err}, 32'h0);
    chk("reset_mem", {29'b0, o_mem_en, o_mem_readEn, o_mem_writeEn} | o_mem_add | o_mem_data, 32'h0);
    i_rst_n = 1'b1;
    chk_on  = 1'b1;

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    // Byte read-modify-write and both extensions.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h000000A5, 0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA5223344);
    do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0, 1'b1, 32'hFFFFFFA5, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 0, 1'b1, 32'h000000A5, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0, 1'b1, 32'hFFFFA522, 1'b0, 1'b0, 32'h0);
    // Error cases.
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    // Back-pressure on the response.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    // Word 0 is read-only zero.
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset in the WR cycle of a byte store: write and response are dropped.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b00; i_req_addr = 32'h31;
    i_req_wdata = 32'h77;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("rst_test_in_wr", {31'b0, o_mem_writeEn}, 32'h1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_drop_en", {30'b0, o_mem_en, o_mem_writeEn}, 32'h0);
    chk("rst_no_rsp", {31'b0, o_rsp_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, o_req_ready}, 32'h1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", {31'b0, o_req_ready}, 32'h1);
    chk("post_rst_no_rsp", {31'b0, o_rsp_valid}, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 200; t++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      r_sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_ad  = 32'($urandom_range(0, 127));
      if (r_sz != 2'b11 && $urandom_range(0, 3) != 0) r_ad = r_ad & ~((32'h1 << r_sz) - 32'h1);
      if ($urandom_range(0, 19) == 0) r_ad = (r_ad & 32'h3) | 32'h400;
      do_req(r_we, r_sz, r_uns, r_ad, $urandom(), $urandom_range(0, 3),
             1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    // Final sweep: every word readable and equal to the model image.
    for (int w = 0; w < 32; w++) begin
      do_req(1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
